mult_booth_seq: RTL and testbench
=================================

Name: mult_booth_seq

Overview:
- Parametrised sequential radix-2 Booth multiplier for the datapath's MULT/MULTU path.
- Computes a 2*WIDTH-bit product, signed or unsigned, using one Booth step per clock.
- Uses a start/busy/done handshake and holds its result until the next start.
- Feeds the HI/LO registers directly. The control unit stalls on busy.

Parameters:
- WIDTH, 32, operand width in bits (legal range 4..64).
- CNT_W, $clog2(WIDTH+2), iteration counter width (derived; do not override).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request pulse; sampled only when busy=0.
- is_signed  input  1  1 = signed (MULT), 0 = unsigned (MULTU); latched at start.
- multiplicand  input  WIDTH  operand A; latched at start.
- multiplier  input  WIDTH  operand B; latched at start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when mult_hi/mult_lo become valid.
- mult_hi  output  WIDTH  upper half of the product.
- mult_lo  output  WIDTH  lower half of the product.
- overflow  output  1  product does not fit in WIDTH signed/unsigned bits (see Optional Feature).

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset: busy=0, done=0, mult_hi=0, mult_lo=0, overflow=0; FSM goes to IDLE; counter, A, Q and Q_1 are cleared.
- FSM states: IDLE, RUN.
  - IDLE -> RUN when start=1.
  - RUN -> IDLE after the final iteration.
- Load, at edge E0 (IDLE with start=1):
  - Operands are extended to WIDTH+1 bits: sign-extended if is_signed=1, zero-extended otherwise.
  - A=0, Q=extended multiplier, Q_1=0, M=extended multiplicand, cnt=0, busy=1.
- RUN, one iteration per edge E1..E(WIDTH+1):
  - Case {Q[0],Q_1}: 01 -> A=A+M; 10 -> A=A-M; otherwise A unchanged. All arithmetic is WIDTH+1 bits, wraparound.
  - Then arithmetic right shift of {A,Q,Q_1} by one, with A's MSB replicated.
  - cnt increments each iteration.
- Finish, at edge E(WIDTH+1), i.e. when cnt==WIDTH at the edge:
  - {mult_hi,mult_lo} = low 2*WIDTH bits of {A,Q} after the final shift.
  - done=1, busy=0, FSM -> IDLE.
- Latency: done is high in the cycle after edge E(WIDTH+1), i.e. WIDTH+1 clocks after the start edge (33 for WIDTH=32).
- done is cleared at the next edge.
- Outputs hold their value until the next completed operation. They are never cleared by start, only by reset.
- start while busy=1 is ignored and not queued.
- start in the done cycle is accepted, since the FSM is in IDLE; back-to-back throughput is one operation per WIDTH+2 cycles.
- Operand or is_signed changes during RUN have no effect.
- Reset mid-operation aborts the operation; the reset values above apply at that edge.
- reset and start in the same cycle: reset wins.

Optional Feature:
- Macro: MULT_OVERFLOW_EN.
- Defined: overflow is registered together with done. It is 1 when:
  - signed mode: mult_hi is not all copies of mult_lo[WIDTH-1];
  - unsigned mode: mult_hi is nonzero.
- overflow holds its value like mult_hi/mult_lo.
- Undefined: the overflow port still exists but is tied to 0, and no comparison logic is generated.

Decomposition:
- Package mult_pkg holds:
  - the state enum (MULT_IDLE, MULT_RUN);
  - Booth code constants (BOOTH_ADD=2'b01, BOOTH_SUB=2'b10).
- Sub-module booth_step (combinational, parametrised by WIDTH+1):
  - inputs A, Q, Q_1, M;
  - outputs next A, Q, Q_1 (add/sub plus arithmetic shift).
- The top level holds the FSM, counter, operand registers and output registers.

Test Plan:
- Signed small values: 7 * 6 -> after 33 cycles done=1, hi=0x00000000, lo=0x0000002A. Then -3 * 5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- Unsigned vs signed: 0xFFFFFFFF * 0xFFFFFFFF with is_signed=0 -> hi=0xFFFFFFFE, lo=0x00000001. The same operands with is_signed=1 -> hi=0, lo=1.
- Signed corner: 0x80000000 * 0x80000000 -> hi=0x40000000, lo=0. With MULT_OVERFLOW_EN, overflow=1. The 7*6 case gives overflow=0.
- Handshake:
  - start pulses during busy are ignored;
  - a new start in the done cycle yields a second correct result WIDTH+2 cycles after the first start;
  - done is exactly one cycle wide;
  - outputs hold their value between operations.
- Reset mid-operation: assert reset at cycle 10 of RUN -> next cycle busy=0, done=0, hi=lo=0. A fresh 2*3 afterwards gives lo=6.
- Parametrisation: WIDTH=8, random signed and unsigned pairs -> the result matches a reference product and done arrives 9 cycles after start.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential radix-2 Booth multiplier.
package mult_pkg;

    typedef enum logic [0:0] {
        MULT_IDLE = 1'b0,
        MULT_RUN  = 1'b1
    } mult_state_e;

    localparam logic [1:0] BOOTH_ADD = 2'b01;
    localparam logic [1:0] BOOTH_SUB = 2'b10;

endpackage

// File: rtl/mult_booth_seq_booth_step.sv
// One radix-2 Booth iteration: conditional add/subtract of M into A, then an
// arithmetic right shift of {A,Q,Q_1}.
module booth_step
    import mult_pkg::*;
#(
    parameter int N = 33
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] q,
    input  logic         q_1,
    input  logic [N-1:0] m,
    output logic [N-1:0] a_next,
    output logic [N-1:0] q_next,
    output logic         q_1_next
);

    logic [N-1:0] sum_s;

    // Booth recode of the current multiplier bit pair selects add, subtract or hold.
    always_comb begin
        sum_s = a;
        case ({q[0], q_1})
            BOOTH_ADD: sum_s = a + m;
            BOOTH_SUB: sum_s = a - m;
            default:   sum_s = a;
        endcase
    end

    // Arithmetic shift right of the concatenated {A,Q,Q_1} by one bit.
    always_comb begin
        a_next   = {sum_s[N-1], sum_s[N-1:1]};
        q_next   = {sum_s[0], q[N-1:1]};
        q_1_next = q[0];
    end

endmodule

// File: rtl/mult_booth_seq.sv
// Sequential radix-2 Booth multiplier, one step per clock, start/busy/done handshake.
// Optional MULT_OVERFLOW_EN adds a registered overflow flag; otherwise overflow is 0.
module mult_booth_seq
    import mult_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 2)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] mult_hi,
    output logic [WIDTH-1:0] mult_lo,
    output logic             overflow
);

    localparam int XW = WIDTH + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH);

    mult_state_e      state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [XW-1:0]    a_r;
    logic [XW-1:0]    q_r;
    logic             q1_r;
    logic [XW-1:0]    m_r;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;

    logic [XW-1:0]    a_nxt_s;
    logic [XW-1:0]    q_nxt_s;
    logic             q1_nxt_s;
    logic [XW-1:0]    mcand_ext_s;
    logic [XW-1:0]    mplier_ext_s;
    logic [WIDTH-1:0] fin_hi_s;
    logic [WIDTH-1:0] fin_lo_s;
    logic             finish_s;

    booth_step #(.N(XW)) u_step (
        .a        (a_r),
        .q        (q_r),
        .q_1      (q1_r),
        .m        (m_r),
        .a_next   (a_nxt_s),
        .q_next   (q_nxt_s),
        .q_1_next (q1_nxt_s)
    );

    // Operand extension by one bit makes the same Booth loop serve signed and unsigned.
    always_comb begin
        mcand_ext_s  = {is_signed & multiplicand[WIDTH-1], multiplicand};
        mplier_ext_s = {is_signed & multiplier[WIDTH-1], multiplier};
        fin_hi_s     = {a_nxt_s[WIDTH-2:0], q_nxt_s[WIDTH]};
        fin_lo_s     = q_nxt_s[WIDTH-1:0];
        finish_s     = (state_r == MULT_RUN) && (cnt_r == LAST_CNT);
    end

    // Control FSM, iteration counter, operand registers and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= MULT_IDLE;
            cnt_r   <= '0;
            a_r     <= '0;
            q_r     <= '0;
            q1_r    <= 1'b0;
            m_r     <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            hi_r    <= '0;
            lo_r    <= '0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                MULT_IDLE: begin
                    if (start) begin
                        a_r     <= '0;
                        q_r     <= mplier_ext_s;
                        q1_r    <= 1'b0;
                        m_r     <= mcand_ext_s;
                        cnt_r   <= '0;
                        busy_r  <= 1'b1;
                        state_r <= MULT_RUN;
                    end
                end
                MULT_RUN: begin
                    a_r   <= a_nxt_s;
                    q_r   <= q_nxt_s;
                    q1_r  <= q1_nxt_s;
                    cnt_r <= cnt_r + CNT_W'(1);
                    if (finish_s) begin
                        hi_r    <= fin_hi_s;
                        lo_r    <= fin_lo_s;
                        done_r  <= 1'b1;
                        busy_r  <= 1'b0;
                        state_r <= MULT_IDLE;
                    end
                end
                default: begin
                    state_r <= MULT_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

`ifdef MULT_OVERFLOW_EN
    logic sign_r;
    logic ovf_r;
    logic ovf_s;

    // The product fits when the high half only repeats the sign (signed) or is zero (unsigned).
    always_comb begin
        if (sign_r) begin
            ovf_s = (fin_hi_s != {WIDTH{fin_lo_s[WIDTH-1]}});
        end else begin
            ovf_s = |fin_hi_s;
        end
    end

    // Mode latch at load and overflow capture alongside the result.
    always_ff @(posedge clk) begin
        if (reset) begin
            sign_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            if ((state_r == MULT_IDLE) && start) begin
                sign_r <= is_signed;
            end
            if (finish_s) begin
                ovf_r <= ovf_s;
            end
        end
    end

    assign overflow = ovf_r;
`else
    assign overflow = 1'b0;
`endif

    assign busy    = busy_r;
    assign done    = done_r;
    assign mult_hi = hi_r;
    assign mult_lo = lo_r;

endmodule

// File: tb/tb_mult_booth_seq.sv
// Self-checking bench for mult_booth_seq: WIDTH=32 and WIDTH=8 instances.
module tb_mult_booth_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        w_start, w_sgn, w_busy, w_done, w_ovf;
    logic [31:0] w_a, w_b, w_hi, w_lo;
    logic        n_start, n_sgn, n_busy, n_done, n_ovf;
    logic [7:0]  n_a, n_b, n_hi, n_lo;

    int total = 0;
    int bad   = 0;

    mult_booth_seq #(.WIDTH(32)) dut32 (
        .clk(clk), .reset(reset), .start(w_start), .is_signed(w_sgn),
        .multiplicand(w_a), .multiplier(w_b), .busy(w_busy), .done(w_done),
        .mult_hi(w_hi), .mult_lo(w_lo), .overflow(w_ovf)
    );

    mult_booth_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(n_start), .is_signed(n_sgn),
        .multiplicand(n_a), .multiplier(n_b), .busy(n_busy), .done(n_done),
        .mult_hi(n_hi), .mult_lo(n_lo), .overflow(n_ovf)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        bit          sgn;
        logic [31:0] hi;
        logic [31:0] lo;
        bit          ovf;
    } vec_t;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain integer product of the operands interpreted per mode.
    function automatic void ref_mul(input int w, input logic [63:0] a, input logic [63:0] b,
                                    input bit sgn, output logic [127:0] prod, output bit ovf);
        logic signed [127:0] ea, eb, p;
        ea = {64'd0, a};
        eb = {64'd0, b};
        if (sgn && a[w-1]) ea = ea - (128'sd1 <<< w);
        if (sgn && b[w-1]) eb = eb - (128'sd1 <<< w);
        p = ea * eb;
        if (sgn) ovf = (p < -(128'sd1 <<< (w-1))) || (p >= (128'sd1 <<< (w-1)));
        else     ovf = (p >= (128'sd1 <<< w));
        prod = p & ((128'd1 << (2*w)) - 128'd1);
    endfunction

    function automatic bit exp_ovf(input bit model_ovf);
`ifdef MULT_OVERFLOW_EN
        return model_ovf;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic done_of(input int w);
        return (w == 32) ? w_done : n_done;
    endfunction

    function automatic logic [127:0] prod_of(input int w);
        return (w == 32) ? {64'd0, w_hi, w_lo} : {112'd0, n_hi, n_lo};
    endfunction

    function automatic logic ovf_of(input int w);
        return (w == 32) ? w_ovf : n_ovf;
    endfunction

    // Pulse start for one edge, then scramble operands to show they are ignored during RUN.
    task automatic launch(input int w, input logic [63:0] a, input logic [63:0] b, input bit sgn);
        if (w == 32) begin
            w_a = a[31:0]; w_b = b[31:0]; w_sgn = sgn; w_start = 1'b1;
        end else begin
            n_a = a[7:0]; n_b = b[7:0]; n_sgn = sgn; n_start = 1'b1;
        end
        @(posedge clk); #1;
        w_start = 1'b0; n_start = 1'b0;
        w_a = $urandom; w_b = $urandom; w_sgn = 1'($urandom_range(0, 1));
        n_a = 8'($urandom); n_b = 8'($urandom); n_sgn = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_done(input int w, output int lat);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!done_of(w) && lat < 200);
    endtask

    task automatic check_result(input string name, input int w, input logic [63:0] a,
                                input logic [63:0] b, input bit sgn, input int lat);
        logic [127:0] p;
        bit o;
        ref_mul(w, a, b, sgn, p, o);
        check({name, "_lat"}, 128'(lat), 128'(w + 1));
        check({name, "_prod"}, prod_of(w), p);
        check({name, "_ovf"}, 128'(ovf_of(w)), 128'(exp_ovf(o)));
    endtask

    task automatic run_check(input string name, input int w, input logic [63:0] a,
                             input logic [63:0] b, input bit sgn);
        int lat;
        launch(w, a, b, sgn);
        wait_done(w, lat);
        check_result(name, w, a, b, sgn, lat);
    endtask

    initial begin
        vec_t vt[5];
        int lat;
        logic [31:0] held_hi, held_lo;

        vt[0] = '{32'd7,          32'd6,          1'b1, 32'h00000000, 32'h0000002A, 1'b0};
        vt[1] = '{32'hFFFFFFFD,   32'd5,          1'b1, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0};
        vt[2] = '{32'hFFFFFFFF,   32'hFFFFFFFF,   1'b0, 32'hFFFFFFFE, 32'h00000001, 1'b1};
        vt[3] = '{32'hFFFFFFFF,   32'hFFFFFFFF,   1'b1, 32'h00000000, 32'h00000001, 1'b0};
        vt[4] = '{32'h80000000,   32'h80000000,   1'b1, 32'h40000000, 32'h00000000, 1'b1};

        reset = 1'b1;
        w_start = 1'b0; w_sgn = 1'b0; w_a = '0; w_b = '0;
        n_start = 1'b0; n_sgn = 1'b0; n_a = '0; n_b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_state32", {w_busy, w_done, w_ovf, w_hi, w_lo}, '0);
        check("rst_state8",  {n_busy, n_done, n_ovf, n_hi, n_lo}, '0);
        reset = 1'b0;

        // Directed vectors from the table.
        for (int i = 0; i < 5; i++) begin
            launch(32, {32'd0, vt[i].a}, {32'd0, vt[i].b}, vt[i].sgn);
            wait_done(32, lat);
            check($sformatf("vec%0d_lat", i), 128'(lat), 128'd33);
            check($sformatf("vec%0d_hi", i), 128'(w_hi), 128'(vt[i].hi));
            check($sformatf("vec%0d_lo", i), 128'(w_lo), 128'(vt[i].lo));
            check($sformatf("vec%0d_ovf", i), 128'(w_ovf), 128'(exp_ovf(vt[i].ovf)));
        end

        // Start pulses while busy must be ignored.
        launch(32, 64'd100, 64'hFFFFFFF9, 1'b1);
        lat = 0;
        do begin
            if (lat == 3 || lat == 7) begin
                w_start = 1'b1; w_a = 32'd5; w_b = 32'd5; w_sgn = 1'b0;
            end
            @(posedge clk); #1;
            w_start = 1'b0;
            lat++;
            if (lat == 10) check("busy_mid", 128'(w_busy), 128'd1);
        end while (!w_done && lat < 200);
        check_result("hs_ignore", 32, 64'd100, 64'hFFFFFFF9, 1'b1, lat);

        // Start accepted in the done cycle; done is one cycle wide; outputs held.
        held_hi = w_hi;
        held_lo = w_lo;
        launch(32, 64'd12345, 64'd678, 1'b0);
        check("done_width", 128'(w_done), 128'd0);
        check("hold_during_run", {w_hi, w_lo}, {held_hi, held_lo});
        wait_done(32, lat);
        check_result("b2b", 32, 64'd12345, 64'd678, 1'b0, lat);
        held_hi = w_hi;
        held_lo = w_lo;
        repeat (5) @(posedge clk);
        #1;
        check("hold_idle", {w_done, w_busy, w_hi, w_lo}, {2'b00, held_hi, held_lo});

        // Reset at cycle 10 of RUN aborts, then a fresh operation works.
        launch(32, 64'd123, 64'd456, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("rst_mid", {w_busy, w_done, w_ovf, w_hi, w_lo}, '0);
        run_check("after_rst", 32, 64'd2, 64'd3, 1'b1);
        check("after_rst_lo", 128'(w_lo), 128'd6);

        // Reset and start together: reset wins.
        w_start = 1'b1; w_a = 32'd9; w_b = 32'd9; reset = 1'b1;
        @(posedge clk); #1;
        w_start = 1'b0; reset = 1'b0;
        check("rst_beats_start", 128'(w_busy), 128'd0);
        @(posedge clk); #1;
        check("rst_beats_start2", {w_busy, w_done}, '0);

        // Random operands against the reference model.
        for (int i = 0; i < 40; i++) begin
            run_check($sformatf("r8_%0d", i), 8, 64'($urandom_range(0, 255)),
                      64'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 12; i++) begin
            run_check($sformatf("r32_%0d", i), 32, 64'($urandom), 64'($urandom),
                      1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
